mips_bus_interface: RTL and testbench

MIPS_BUS_INTERFACE -- requirements
Module: mips_bus_interface

---
 rtl/mips_bus_pkg.sv | 46 ++++
 rtl/mips_lane_align.sv | 45 ++++
 rtl/mips_bus_interface.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_bus_interface.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS core to Avalon bus bridge.
// Holds the FSM state enum, the access-size enum, the wait-counter width
// and the byteenable / alignment helpers used by the bridge.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Width of the consecutive-waitrequest counter.
  localparam int unsigned WAIT_CNT_W = 16;

  // Lane enables for an access of the given size at the given byte offset.
  // Size encoding 3 is treated as a word.
  function automatic logic [3:0] byteenable_for(input logic [1:0] size,
                                                input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << offset;
      SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = offset[0];
      default: m = (offset != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Combinational byte-lane steering shared by both bus directions.
//   size_i, offset_i, unsigned_i : access size, byte offset, zero-extend flag
//   wdata_i -> wdata_o           : store data (lane 0 upward) replicated to
//                                  every lane the access could hit
//   rdata_i -> rdata_o           : bus word reduced to the addressed lane and
//                                  sign/zero extended to 32 bits
module mips_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  // Only the low half of the shifted word is ever needed for byte/half loads.
  logic [15:0] lane_w;

  assign lane_w = 16'(rdata_i >> {offset_i, 3'b000});

  always_comb begin
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h000000, lane_w[7:0]}
                             : {{24{lane_w[7]}}, lane_w[7:0]};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0000, lane_w}
                             : {{16{lane_w[15]}}, lane_w};
      end
      default: begin
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_interface.sv
// Bridges a MIPS instruction-fetch port and load/store port onto a single
// Avalon-MM master. Data requests win over fetches; one transaction at a time.
//   clk, reset (sync, active-low)
//   if_req/if_addr  -> if_ready/if_instr               instruction fetch
//   mem_req/we/addr/size/unsigned/wdata
//                   -> mem_ready/mem_rdata/mem_err      load/store
//   address/read/write/writedata/byteenable, waitrequest/readdata  Avalon
//   busy : high whenever not IDLE
// WAIT_LIMIT consecutive waitrequest cycles abort the transaction (0 = never).
module mips_bus_interface
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT_M1 =
    (WAIT_LIMIT == 0) ? '0 : WAIT_CNT_W'(WAIT_LIMIT - 1);

  state_e                state_q, state_d;
  logic [31:0]           address_q, address_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           if_instr_q, if_instr_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  fetch_q, fetch_d;
  logic                  err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;

  logic [1:0]  la_size;
  logic [1:0]  la_off;
  logic        la_uns;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        wait_hit;
  logic        unused_if_lo;

  // Fetches are always word-aligned on the bus.
  assign unused_if_lo = ^if_addr[1:0];

  // One aligner serves both directions: in IDLE it shapes the incoming store
  // data, during the bus cycle it extends the load using the latched fields.
  always_comb begin
    if (state_q == IDLE) begin
      la_size = mem_size;
      la_off  = mem_addr[1:0];
      la_uns  = mem_unsigned;
    end else begin
      la_size = size_q;
      la_off  = off_q;
      la_uns  = uns_q;
    end
  end

  mips_lane_align u_align (
    .size_i     (la_size),
    .offset_i   (la_off),
    .unsigned_i (la_uns),
    .wdata_i    (mem_wdata),
    .wdata_o    (st_data),
    .rdata_i    (readdata),
    .rdata_o    (ld_data)
  );

  // The cycle that would be the WAIT_LIMIT-th consecutive wait aborts instead.
  assign wait_hit = (WAIT_LIMIT != 0) && (wait_q == LIMIT_M1);

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if_instr_d  = if_instr_q;
    mem_rdata_d = mem_rdata_q;
    wait_d      = wait_q;
    fetch_d     = fetch_q;
    err_d       = err_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;

    case (state_q)
      IDLE: begin
        wait_d = '0;
        err_d  = 1'b0;
        if (mem_req) begin
          fetch_d = 1'b0;
          size_d  = mem_size;
          off_d   = mem_addr[1:0];
          uns_d   = mem_unsigned;
          if (misaligned(mem_size, mem_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d   = DATA;
            address_d = {mem_addr[31:2], 2'b00};
            read_d    = ~mem_we;
            write_d   = mem_we;
            be_d      = byteenable_for(mem_size, mem_addr[1:0]);
            wdata_d   = st_data;
          end
        end else if (if_req) begin
          fetch_d   = 1'b1;
          state_d   = FETCH;
          address_d = {if_addr[31:2], 2'b00};
          read_d    = 1'b1;
          write_d   = 1'b0;
          be_d      = 4'b1111;
        end
      end
      FETCH, DATA: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          wait_d  = '0;
          state_d = RESP;
          if (state_q == FETCH) begin
            if_instr_d = readdata;
          end else if (read_q) begin
            mem_rdata_d = ld_data;
          end
        end else if (wait_hit) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          wait_d  = '0;
          state_d = RESP;
          if (state_q == FETCH) begin
            if_instr_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      if_instr_q  <= '0;
      mem_rdata_q <= '0;
      wait_q      <= '0;
      fetch_q     <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if_instr_q  <= if_instr_d;
      mem_rdata_q <= mem_rdata_d;
      wait_q      <= wait_d;
      fetch_q     <= fetch_d;
      err_q       <= err_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign if_instr   = if_instr_q;
  assign mem_rdata  = mem_rdata_q;
  assign busy       = (state_q != IDLE);
  assign if_ready   = (state_q == RESP) && fetch_q;
  assign mem_ready  = (state_q == RESP) && !fetch_q && !err_q;
  assign mem_err    = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mips_bus_interface.sv
// Scoreboard bench for mips_bus_interface: the stimulus process predicts each
// bus cycle and each response (value and cycle of arrival) from the access
// rules and queues them; independent monitors pop and compare.
module tb_mips_bus_interface;

  localparam int unsigned MAIN_LIMIT = 255;
  localparam int unsigned T4_LIMIT   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT
  logic        if_req = 0, mem_req = 0, mem_we = 0, mem_unsigned = 0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic        waitrequest = 0;
  logic [31:0] readdata = '0;
  logic        if_ready, mem_ready, mem_err, read, write, busy;
  logic [31:0] if_instr, mem_rdata, address, writedata;
  logic [3:0]  byteenable;

  mips_bus_interface #(.WAIT_LIMIT(MAIN_LIMIT)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .busy(busy)
  );

  // Second instance with a short timeout and a slave that never answers
  logic        t4_if_req = 0, t4_mem_req = 0;
  logic [31:0] t4_if_addr = 32'h0000_0100, t4_mem_addr = 32'h0000_0040;
  logic [1:0]  t4_mem_size = 2'd2;
  logic        t4_waitrequest = 1'b1;
  logic [31:0] t4_readdata = 32'h1234_5678;
  logic        t4_if_ready, t4_mem_ready, t4_mem_err, t4_read, t4_write, t4_busy;
  logic [31:0] t4_if_instr, t4_mem_rdata, t4_address, t4_writedata;
  logic [3:0]  t4_byteenable;

  mips_bus_interface #(.WAIT_LIMIT(T4_LIMIT)) u_dut4 (
    .clk(clk), .reset(reset),
    .if_req(t4_if_req), .if_addr(t4_if_addr), .if_ready(t4_if_ready), .if_instr(t4_if_instr),
    .mem_req(t4_mem_req), .mem_we(1'b0), .mem_addr(t4_mem_addr), .mem_size(t4_mem_size),
    .mem_unsigned(1'b0), .mem_wdata(32'h0),
    .mem_ready(t4_mem_ready), .mem_rdata(t4_mem_rdata), .mem_err(t4_mem_err),
    .address(t4_address), .read(t4_read), .write(t4_write), .waitrequest(t4_waitrequest),
    .writedata(t4_writedata), .byteenable(t4_byteenable), .readdata(t4_readdata), .busy(t4_busy)
  );

  int unsigned ncmp = 0, nfail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { bit is_fetch; bit err; logic [31:0] data; int unsigned at; } resp_t;
  typedef struct { logic [31:0] addr; bit rd; bit wr; logic [3:0] be; logic [31:0] wdata; int unsigned ncyc; } bus_t;
  typedef struct { int unsigned nwait; logic [31:0] rdata; } slv_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  slv_t  slv_q[$];

  logic [31:0] last_mem = '0, last_if = '0;

  // ---------------- reference rules ----------------
  function automatic int unsigned width_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    int unsigned w;
    w = width_of(size);
    be = '0;
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + w);
    return be;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] wd, input logic [1:0] size);
    logic [31:0] r;
    int unsigned w;
    w = width_of(size);
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] size,
                                           input logic [1:0] off, input bit uns);
    logic [31:0] v, mask;
    int unsigned w;
    w = width_of(size);
    v = rd >> (8 * off);
    if (w < 4) begin
      mask = (32'h1 << (8 * w)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*w-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- Avalon slave ----------------
  bit          s_active = 0;
  int unsigned s_cnt = 0;
  slv_t        s_cur;
  always @(negedge clk) begin
    if (read || write) begin
      if (!s_active) begin
        if (slv_q.size() > 0) s_cur = slv_q.pop_front();
        else s_cur = '{nwait: 0, rdata: 32'hDEAD_BEEF};
        s_active = 1;
        s_cnt = 0;
      end
      if (s_cnt < s_cur.nwait) begin
        waitrequest = 1'b1;
        s_cnt++;
      end else begin
        waitrequest = 1'b0;
      end
      readdata = s_cur.rdata;
    end else begin
      s_active = 0;
      waitrequest = 1'($urandom_range(0, 1));
      readdata = $urandom;
    end
  end

  // ---------------- bus monitor ----------------
  bit          b_active = 0;
  int unsigned b_cnt = 0;
  bus_t        b_cur;
  always @(negedge clk) begin
    if (read || write) begin
      if (!b_active) begin
        b_active = 1;
        b_cnt = 0;
        if (bus_q.size() == 0) begin
          check("unexpected_bus_cycle", 64'(address), 64'hFFFF_FFFF_FFFF_FFFF);
          b_cur = '{addr: address, rd: read, wr: write, be: byteenable, wdata: writedata, ncyc: 0};
        end else begin
          b_cur = bus_q.pop_front();
        end
      end
      check("bus_addr", 64'(address), 64'(b_cur.addr));
      check("bus_rw", 64'({read, write}), 64'({b_cur.rd, b_cur.wr}));
      check("bus_be", 64'(byteenable), 64'(b_cur.be));
      if (b_cur.wr) check("bus_wdata", 64'(writedata), 64'(b_cur.wdata));
      b_cnt++;
    end else if (b_active) begin
      b_active = 0;
      check("bus_cycles", 64'(b_cnt), 64'(b_cur.ncyc));
    end
  end

  // ---------------- response monitor ----------------
  bit prev_pulse = 0;
  always @(negedge clk) begin
    logic [2:0] p;
    resp_t e;
    p = {if_ready, mem_ready, mem_err};
    if (p != 3'b000) begin
      check("resp_gap", 64'(prev_pulse), 64'd0);
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 64'(p), 64'd0);
      end else begin
        e = resp_q.pop_front();
        check("resp_kind", 64'(p), e.is_fetch ? 64'b100 : (e.err ? 64'b001 : 64'b010));
        check("resp_data", e.is_fetch ? 64'(if_instr) : 64'(mem_rdata), 64'(e.data));
        check("resp_cycle", 64'(cyc), 64'(e.at));
      end
    end
    prev_pulse = (p != 3'b000);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit do_f, input logic [31:0] f_addr, input int unsigned f_nw,
                       input logic [31:0] f_rd,
                       input bit do_d, input bit we, input logic [31:0] d_addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd,
                       input int unsigned d_nw, input logic [31:0] d_rd);
    int unsigned t, c, deadline;
    bit to, mis, pend_f, pend_d;
    logic [31:0] v;
    t = cyc;
    if (do_d) begin
      mis = (size == 2'd1 && d_addr[0]) || (size == 2'd2 && d_addr[1:0] != 2'b00);
      if (mis) begin
        resp_q.push_back('{is_fetch: 0, err: 1, data: last_mem, at: t + 1});
        t = t + 1;
      end else begin
        to = (d_nw >= MAIN_LIMIT);
        c = to ? MAIN_LIMIT : d_nw + 1;
        slv_q.push_back('{nwait: d_nw, rdata: d_rd});
        bus_q.push_back('{addr: {d_addr[31:2], 2'b00}, rd: !we, wr: we,
                          be: ref_be(size, d_addr[1:0]), wdata: ref_store(wd, size), ncyc: c});
        if (!we && !to) last_mem = ref_load(d_rd, size, d_addr[1:0], uns);
        resp_q.push_back('{is_fetch: 0, err: to, data: last_mem, at: t + 1 + c});
        t = t + 1 + c;
      end
      t = t + 1;
    end
    if (do_f) begin
      to = (f_nw >= MAIN_LIMIT);
      c = to ? MAIN_LIMIT : f_nw + 1;
      v = to ? 32'h0 : f_rd;
      last_if = v;
      slv_q.push_back('{nwait: f_nw, rdata: f_rd});
      bus_q.push_back('{addr: {f_addr[31:2], 2'b00}, rd: 1, wr: 0, be: 4'hF, wdata: '0, ncyc: c});
      resp_q.push_back('{is_fetch: 1, err: 0, data: v, at: t + 1 + c});
      t = t + 1 + c;
    end
    if_addr = f_addr; mem_we = we; mem_addr = d_addr; mem_size = size;
    mem_unsigned = uns; mem_wdata = wd;
    if_req = do_f; mem_req = do_d;
    pend_f = do_f; pend_d = do_d;
    deadline = t + 20;
    while (pend_f || pend_d) begin
      @(negedge clk);
      if (mem_ready || mem_err) begin mem_req = 0; pend_d = 0; end
      if (if_ready) begin if_req = 0; pend_f = 0; end
      if (cyc > deadline) begin
        check("resp_timeout", 64'({pend_f, pend_d}), 64'd0);
        if_req = 0; mem_req = 0; pend_f = 0; pend_d = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic t4_test();
    int unsigned n, rc;
    bit got;
    n = cyc; rc = 0; got = 0;
    t4_mem_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t4_read) rc++;
      if (t4_mem_err || t4_mem_ready) got = 1;
    end
    check("t4_err_pulse", 64'({t4_mem_err, t4_mem_ready}), 64'b10);
    check("t4_rd_cycles", 64'(rc), 64'(T4_LIMIT));
    check("t4_err_cycle", 64'(cyc), 64'(n + 1 + T4_LIMIT));
    t4_mem_req = 0;
    @(negedge clk);
    check("t4_err_single", 64'(t4_mem_err), 64'd0);
    n = cyc; rc = 0; got = 0;
    t4_if_req = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t4_read) rc++;
      if (t4_if_ready) got = 1;
    end
    check("t4_fetch_ready", 64'(t4_if_ready), 64'd1);
    check("t4_fetch_instr", 64'(t4_if_instr), 64'd0);
    check("t4_fetch_cycles", 64'(rc), 64'(T4_LIMIT));
    t4_if_req = 0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({read, write, if_ready, mem_ready, mem_err, busy, byteenable}), 64'd0);
    check({tag, "_addr"}, 64'(address), 64'd0);
    check({tag, "_wdata"}, 64'(writedata), 64'd0);
    check({tag, "_instr"}, 64'(if_instr), 64'd0);
    check({tag, "_rdata"}, 64'(mem_rdata), 64'd0);
  endtask

  task automatic reset_midflight();
    int unsigned seen;
    slv_q.push_back('{nwait: 50, rdata: 32'hCAFE_F00D});
    bus_q.push_back('{addr: 32'h3000, rd: 1, wr: 0, be: 4'hF, wdata: '0, ncyc: 3});
    mem_we = 0; mem_addr = 32'h3000; mem_size = 2'd2; mem_unsigned = 0;
    mem_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (read) seen++;
    end
    check("rst_read_seen", 64'(seen), 64'd3);
    reset = 0;
    @(negedge clk);
    check_reset_outputs("rst_abort");
    @(negedge clk);
    check("rst_ignore_req", 64'({busy, read, write}), 64'd0);
    mem_req = 0;
    reset = 1;
    last_mem = '0; last_if = '0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1;
    @(negedge clk);

    t4_test();

    // signed byte load, upper lane
    issue(0, 0, 0, 0, 1, 0, 32'h1003, 2'd0, 0, 32'h0, 0, 32'h80FF_7F01);
    // half store to upper half
    issue(0, 0, 0, 0, 1, 1, 32'h2002, 2'd1, 0, 32'h0000_BEEF, 0, 32'h0);
    // misaligned word load
    issue(0, 0, 0, 0, 1, 0, 32'h1002, 2'd2, 0, 32'h0, 0, 32'h0);
    // fetch held off by 5 wait cycles
    issue(1, 32'h0040_0000, 5, 32'h2408_0005, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    // simultaneous requests: data first
    issue(1, 32'h0040_0004, 0, 32'h0000_0000 + 32'h3C01_1001,
          1, 0, 32'h4000, 2'd2, 0, 32'h0, 1, 32'h1357_9BDF);
    // fetch timeout on the main instance
    issue(1, 32'h0040_0008, 300, 32'hFFFF_FFFF, 0, 0, 0, 2'd0, 0, 0, 0, 0);

    reset_midflight();

    for (int it = 0; it < 150; it++) begin
      int unsigned k, fnw, dnw;
      logic [1:0] sz;
      logic [31:0] da;
      k = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      da = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) da[0] = 1'b0;
        if (sz == 2'd2) da[1:0] = 2'b00;
      end
      fnw = ($urandom_range(0, 9) == 9) ? 6 : $urandom_range(0, 3);
      dnw = ($urandom_range(0, 9) == 9) ? 6 : $urandom_range(0, 3);
      issue(k != 1, $urandom, fnw, $urandom,
            k != 0, 1'($urandom_range(0, 1)), da, sz, 1'($urandom_range(0, 1)),
            $urandom, dnw, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    nfail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule
